// File: rtl/float_pkg.sv
// float_pkg: shared float field widths, exponent bias and scheduler FSM states
package float_pkg;
    localparam int EXP_BIAS = 127;
    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-port round-robin grant favouring the port not granted last
module rr_arbiter2 (
    input  logic [1:0] request,
    input  logic       last,
    output logic [1:0] grant
);
    // a lone requester always wins; on contention the other port from last wins
    always_comb grant = (&request) ? (last ? 2'b01 : 2'b10) : request;
endmodule

// File: rtl/float_convert_sched.sv
// float_convert_sched: two requesters sharing one multi-cycle int-to-float normaliser
import float_pkg::*;
module float_convert_sched #(
    parameter int EXP_BIAS  = float_pkg::EXP_BIAS,
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [31:0]          req_data0,
    input  logic [31:0]          req_data1,
    output logic [NUM_PORTS-1:0] req_ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy
);
    state_e              state_q, state_d;
    logic [SIGN_W-1:0]   sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [31:0]         mag_q, mag_d;
    logic                id_q, id_d;
    logic                last_q, last_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic [1:0]          gnt;
    logic [31:0]         op, op_mag;

    rr_arbiter2 u_arb (
        .request(req_valid),
        .last   (last_q),
        .grant  (gnt)
    );

    assign op        = gnt[1] ? req_data1 : req_data0;
    assign op_mag    = op[31] ? ~op + 32'd1 : op;
    assign req_ack   = (state_q == IDLE && rst_n) ? gnt : '0;
    assign busy      = state_q != IDLE;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    // grant/capture in IDLE, shift-normalise in NORM, hold the result in DONE
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mag_d       = mag_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                sign_d = op[31];
                mag_d  = op_mag;
                exp_d  = EXP_W'(EXP_BIAS + 31);
                id_d   = gnt[1];
                last_d = gnt[1];
                if (op == 32'd0) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt[1];
                    rsp_data_d  = 32'd0;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: if (mag_q[31]) begin
                state_d     = DONE;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = {sign_q, exp_q, mag_q[30 -: MAN_W]};
            end else begin
                mag_d = mag_q << 1;
                exp_d = exp_q - EXP_W'(1);
            end
            DONE: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset aborts any conversion and points the arbiter at port 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= '0;
            exp_q       <= '0;
            mag_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mag_q       <= mag_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_float_convert_sched.sv
// tb_float_convert_sched: randomized self-checking bench against an arithmetic float model
module tb_float_convert_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [31:0] req_data [2];
    logic [1:0]  req_ack;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        busy;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_port = 1;

    float_convert_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data0(req_data[0]),
        .req_data1(req_data[1]),
        .req_ack  (req_ack),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int msb(input logic [31:0] m);
        for (int b = 31; b >= 0; b--) if (m[b]) return b;
        return -1;
    endfunction

    function automatic logic [31:0] ref_float(input logic [31:0] x);
        logic [31:0] m;
        int p;
        if (x == 32'd0) return 32'd0;
        m = x[31] ? -x : x;
        p = msb(m);
        return {x[31], 8'(127 + p), 23'((m << (31 - p)) >> 8)};
    endfunction

    function automatic int ref_lat(input logic [31:0] x);
        logic [31:0] m;
        if (x == 32'd0) return 1;
        m = x[31] ? -x : x;
        return 2 + 31 - msb(m);
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) x = -x;
        if ($urandom_range(0, 7) == 0) x = 32'd0;
        return x;
    endfunction

    task automatic wait_ack(output logic [1:0] a, output int t);
        a = 2'b00;
        t = -1000;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ack != 2'b00) begin
                a = req_ack;
                t = cyc;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                t = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] a;
        int t0, t1;
        rst_n = 1'b0;
        req_data[0] = 32'd5;
        req_data[1] = -32'd3;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", req_ack); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ack(a, t0);
        checks++; if (a !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b want 01", a); end
        last_port = 0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(t1);
        checks++; if (t1 - t0 != ref_lat(32'd5)) begin errors++; $display("FAIL reset_first_latency: got %0d want %0d", t1 - t0, ref_lat(32'd5)); end
        checks++; if (rsp_data !== ref_float(32'd5)) begin errors++; $display("FAIL reset_first_data: got %h want %h", rsp_data, ref_float(32'd5)); end
        @(posedge clk); #1;
    endtask

    task automatic test_convert(input int n_rand);
        logic [31:0] vec[$] = '{32'h1, 32'hFFFFFFFF, 32'h5, 32'h7FFFFFFF, 32'h80000000, 32'h0};
        int ports[$] = '{0, 1, 1, 1, 0, 0};
        logic [1:0] a;
        int t0, t1, p;
        for (int i = 0; i < n_rand; i++) begin
            vec.push_back(rand_op());
            ports.push_back(int'($urandom_range(0, 1)));
        end
        rsp_ready = 1'b1;
        foreach (vec[i]) begin
            p = ports[i];
            req_data[p] = vec[i];
            req_valid = 2'(1 << p);
            wait_ack(a, t0);
            checks++; if (a !== 2'(1 << p)) begin errors++; $display("FAIL conv_ack[%0d]: got %b want %b", i, a, 2'(1 << p)); end
            last_port = p;
            @(posedge clk); #1;
            req_valid = 2'b00;
            wait_rsp(t1);
            checks++; if (t1 - t0 != ref_lat(vec[i])) begin errors++; $display("FAIL conv_latency[%0d] op=%h: got %0d want %0d", i, vec[i], t1 - t0, ref_lat(vec[i])); end
            checks++; if (rsp_data !== ref_float(vec[i])) begin errors++; $display("FAIL conv_data[%0d] op=%h: got %h want %h", i, vec[i], rsp_data, ref_float(vec[i])); end
            checks++; if (rsp_id !== 1'(p)) begin errors++; $display("FAIL conv_id[%0d]: got %b want %0d", i, rsp_id, p); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL conv_valid_drop[%0d]: got %b want 0", i, rsp_valid); end
        end
    endtask

    task automatic test_reset_abort();
        logic [1:0] a;
        int t0, t1, seen;
        rsp_ready = 1'b1;
        req_data[0] = 32'd1;
        req_valid = 2'b01;
        wait_ack(a, t0);
        checks++; if (a !== 2'b01) begin errors++; $display("FAIL abort_ack: got %b want 01", a); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({req_ack, rsp_valid, rsp_id, busy} !== 5'b0 || rsp_data !== 32'd0) begin
            errors++; $display("FAIL abort_reset_outputs: ack=%b valid=%b id=%b busy=%b data=%h want all 0", req_ack, rsp_valid, rsp_id, busy, rsp_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_port = 1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_rsp: got %0d valid cycles want 0", seen); end
        @(posedge clk); #1;
        req_data[0] = 32'd9;
        req_valid = 2'b01;
        wait_ack(a, t0);
        checks++; if (a !== 2'b01) begin errors++; $display("FAIL abort_reack: got %b want 01", a); end
        last_port = 0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(t1);
        checks++; if (t1 - t0 != ref_lat(32'd9) || rsp_data !== ref_float(32'd9)) begin
            errors++; $display("FAIL abort_rerun: lat %0d data %h want lat %0d data %h", t1 - t0, rsp_data, ref_lat(32'd9), ref_float(32'd9));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input int n);
        logic [1:0] a;
        logic [31:0] cap;
        int t0, t1, p;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_port = 1;
        rsp_ready = 1'b0;
        req_data[0] = rand_op();
        req_data[1] = rand_op();
        req_valid = 2'b11;
        for (int i = 0; i < n; i++) begin
            p = 1 - last_port;
            wait_ack(a, t0);
            checks++; if (a !== 2'(1 << p)) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", i, a, 2'(1 << p)); end
            last_port = p;
            cap = req_data[p];
            @(posedge clk); #1;
            req_data[p] = rand_op();
            wait_rsp(t1);
            checks++; if (t1 - t0 != ref_lat(cap)) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, t1 - t0, ref_lat(cap)); end
            checks++; if (rsp_data !== ref_float(cap) || rsp_id !== 1'(p)) begin
                errors++; $display("FAIL b2b_result[%0d]: got %h id %b want %h id %0d", i, rsp_data, rsp_id, ref_float(cap), p);
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== ref_float(cap) || rsp_id !== 1'(p) || req_ack !== 2'b00) begin
                    errors++; $display("FAIL b2b_stall[%0d.%0d]: valid=%b data=%h id=%b ack=%b want 1 %h %0d 00", i, k, rsp_valid, rsp_data, rsp_id, req_ack, ref_float(cap), p);
                end
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        req_data[0] = 32'd0;
        req_data[1] = 32'd0;
        test_reset();
        test_convert(24);
        test_reset_abort();
        test_back_to_back(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
